// File: rtl/cpu16_pkg.sv
// Shared constants and types for the 16-bit datapath: opcode/funct encodings,
// datapath width and the execute-stage sequencing states.
package cpu16_pkg;

  localparam int DW       = 16;
  localparam int MD_STEPS = DW;

  localparam logic [3:0] OPC_TYPEA = 4'hF;

  localparam logic [3:0] F_ADD = 4'b0000;
  localparam logic [3:0] F_SUB = 4'b0001;
  localparam logic [3:0] F_AND = 4'b0010;
  localparam logic [3:0] F_OR  = 4'b0011;
  localparam logic [3:0] F_MUL = 4'b0100;
  localparam logic [3:0] F_DIV = 4'b0101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_seq.sv
// Iterative unsigned multiplier / restoring divider: one multiplier or quotient
// bit per cycle over MD_STEPS cycles. Divide-by-zero holds its operands instead.
module muldiv_seq
  import cpu16_pkg::*;
#(
  parameter int DW       = cpu16_pkg::DW,
  parameter int MD_STEPS = DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          is_div,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          done,
  output logic [DW-1:0] lo,
  output logic [DW-1:0] hi,
  output logic          dbz
);

  localparam int CW = $clog2(MD_STEPS);

  logic          busy_q;
  logic          div_q;
  logic          dbz_q;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] acc_q;   // product high half / partial remainder
  logic [DW-1:0] q_q;     // multiplier bits shifting out / quotient bits shifting in
  logic [DW-1:0] m_q;     // multiplicand / divisor

  logic [DW-1:0] acc_n;
  logic [DW-1:0] q_n;
  logic [DW:0]   sum;
  logic [DW:0]   r_sh;
  logic [DW:0]   diff;

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    acc_n = acc_q;
    q_n   = q_q;
    sum   = {1'b0, acc_q} + (q_q[0] ? {1'b0, m_q} : '0);
    r_sh  = {acc_q, q_q[DW-1]};
    diff  = r_sh - {1'b0, m_q};
    if (dbz_q) begin
      acc_n = acc_q;
      q_n   = q_q;
    end else if (div_q) begin
      // Borrow out of the top bit means the trial subtraction failed: restore.
      if (!diff[DW]) begin
        acc_n = diff[DW-1:0];
        q_n   = {q_q[DW-2:0], 1'b1};
      end else begin
        acc_n = r_sh[DW-1:0];
        q_n   = {q_q[DW-2:0], 1'b0};
      end
    end else begin
      acc_n = sum[DW:1];
      q_n   = {sum[0], q_q[DW-1:1]};
    end
  end

  // Results are presented on the final step so the caller can register them on that edge.
  assign done = busy_q && (cnt_q == CW'(MD_STEPS - 1));
  assign lo   = dbz_q ? '1   : q_n;
  assign hi   = dbz_q ? q_q  : acc_n;
  assign dbz  = dbz_q;

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      dbz_q  <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      q_q    <= '0;
      m_q    <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      div_q  <= is_div;
      dbz_q  <= is_div && (b == '0);
      cnt_q  <= '0;
      acc_q  <= '0;
      q_q    <= a;
      m_q    <= b;
    end else if (busy_q) begin
      acc_q <= acc_n;
      q_q   <= q_n;
      cnt_q <= cnt_q + 1'b1;
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/exec_muldiv_unit.sv
// Execute stage: single-cycle ALU (ADD/SUB/AND/OR) plus an iterative MUL/DIV
// sequencer behind a ready/valid handshake; all result outputs are registered.
module exec_muldiv_unit
  import cpu16_pkg::*;
#(
  parameter int DW       = cpu16_pkg::DW,
  parameter int MD_STEPS = DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    opcode,
  input  logic [3:0]    funct,
  input  logic [DW-1:0] op1,
  input  logic [DW-1:0] op2,
  input  logic          r15_sel,
  output logic          out_valid,
  output logic [DW-1:0] Writedata,
  output logic          RegWrite,
  output logic          r15_we,
  output logic [DW-1:0] r15_data,
  output logic          ovf,
  output logic          illegal
);

  state_e state_q, state_n;

  logic          accept;
  logic          legal;
  logic          is_md;
  logic          start;
  logic [DW-1:0] alu_res;
  logic          alu_ovf;
  logic          r15_sel_q;

  logic          md_done;
  logic [DW-1:0] md_lo;
  logic [DW-1:0] md_hi;
  logic          md_dbz;

  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid && in_ready;
  assign legal    = (opcode == OPC_TYPEA) && (funct <= F_DIV);
  assign is_md    = legal && ((funct == F_MUL) || (funct == F_DIV));
  assign start    = accept && is_md;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    unique case (funct)
      F_ADD: begin
        alu_res = op1 + op2;
        alu_ovf = (op1[DW-1] == op2[DW-1]) && (alu_res[DW-1] != op1[DW-1]);
      end
      F_SUB: begin
        alu_res = op1 - op2;
        alu_ovf = (op1[DW-1] != op2[DW-1]) && (alu_res[DW-1] != op1[DW-1]);
      end
      F_AND:   alu_res = op1 & op2;
      F_OR:    alu_res = op1 | op2;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (md_done) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_n;
  end

  muldiv_seq #(
    .DW       (DW),
    .MD_STEPS (MD_STEPS)
  ) u_muldiv_seq (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .is_div (funct == F_DIV),
    .a      (op1),
    .b      (op2),
    .done   (md_done),
    .lo     (md_lo),
    .hi     (md_hi),
    .dbz    (md_dbz)
  );

  // Strobes default low every cycle; data words only move when a result lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      RegWrite  <= 1'b0;
      r15_we    <= 1'b0;
      ovf       <= 1'b0;
      illegal   <= 1'b0;
      Writedata <= '0;
      r15_data  <= '0;
      r15_sel_q <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      RegWrite  <= 1'b0;
      r15_we    <= 1'b0;
      ovf       <= 1'b0;
      illegal   <= 1'b0;
      if (start) r15_sel_q <= r15_sel;
      if (accept && !is_md) begin
        out_valid <= 1'b1;
        if (legal) begin
          RegWrite  <= 1'b1;
          Writedata <= alu_res;
          ovf       <= alu_ovf;
        end else begin
          illegal <= 1'b1;
        end
      end
      if ((state_q == RUN) && md_done) begin
        out_valid <= 1'b1;
        RegWrite  <= 1'b1;
        r15_we    <= r15_sel_q;
        Writedata <= md_lo;
        r15_data  <= md_hi;
        ovf       <= md_dbz;
      end
    end
  end

endmodule

// File: tb/tb_exec_muldiv_unit.sv
// Self-checking bench for exec_muldiv_unit: directed cases plus random traffic
// scored against an arithmetic reference model with per-result latency tracking.
module tb_exec_muldiv_unit;
  import cpu16_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  opcode;
  logic [3:0]  funct;
  logic [15:0] op1;
  logic [15:0] op2;
  logic        r15_sel;
  logic        out_valid;
  logic [15:0] Writedata;
  logic        RegWrite;
  logic        r15_we;
  logic [15:0] r15_data;
  logic        ovf;
  logic        illegal;

  exec_muldiv_unit dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .funct     (funct),
    .op1       (op1),
    .op2       (op2),
    .r15_sel   (r15_sel),
    .out_valid (out_valid),
    .Writedata (Writedata),
    .RegWrite  (RegWrite),
    .r15_we    (r15_we),
    .r15_data  (r15_data),
    .ovf       (ovf),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] wd;
    logic [15:0] r15;
    logic        rw;
    logic        r15we;
    logic        ovf;
    logic        ill;
  } exp_t;

  exp_t        exq[$];
  exp_t        e;
  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          ready_from = 0;
  int          last_acc = 0;
  bit          acc_flag = 0;
  logic [15:0] m_wd = '0, m_r15 = '0;   // model's view of the last result issued
  logic [15:0] h_wd = '0, h_r15 = '0;   // values the outputs must hold between results

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // Reference behaviour from the instruction-set rules, using plain integer arithmetic.
  function automatic exp_t model(input logic [3:0] opc, input logic [3:0] fn,
                                 input logic [15:0] a, input logic [15:0] b, input logic rs);
    exp_t r;
    int   s;
    logic [31:0] p;
    bit   md;
    r.wd = m_wd; r.r15 = m_r15; r.rw = 1'b1; r.r15we = 1'b0; r.ovf = 1'b0; r.ill = 1'b0;
    md = 0;
    if (opc != 4'hF || fn > 4'd5) begin
      r.rw = 1'b0; r.ill = 1'b1;
    end else begin
      case (fn)
        4'd0: begin s = int'($signed(a)) + int'($signed(b)); r.wd = a + b; r.ovf = (s > 32767 || s < -32768); end
        4'd1: begin s = int'($signed(a)) - int'($signed(b)); r.wd = a - b; r.ovf = (s > 32767 || s < -32768); end
        4'd2: r.wd = a & b;
        4'd3: r.wd = a | b;
        4'd4: begin md = 1; p = {16'h0, a} * {16'h0, b}; r.wd = p[15:0]; r.r15 = p[31:16]; end
        default: begin
          md = 1;
          if (b == 16'h0) begin r.wd = 16'hFFFF; r.r15 = a; r.ovf = 1'b1; end
          else begin r.wd = a / b; r.r15 = a % b; end
        end
      endcase
      if (md) r.r15we = rs;
    end
    r.due = cyc + (md ? 17 : 1);
    return r;
  endfunction

  task automatic monitor();
    acc_flag = 0;
    check("in_ready", in_ready, cyc >= ready_from);
    if (exq.size() > 0 && exq[0].due < cyc) begin
      check("result_timeout", 0, 1);
      e = exq.pop_front();
    end
    if (out_valid) begin
      if (exq.size() == 0) check("spurious_out_valid", 1, 0);
      else begin
        e = exq.pop_front();
        check("latency", cyc, e.due);
        check("Writedata", Writedata, e.wd);
        check("r15_data", r15_data, e.r15);
        check("RegWrite", RegWrite, e.rw);
        check("r15_we", r15_we, e.r15we);
        check("ovf", ovf, e.ovf);
        check("illegal", illegal, e.ill);
        h_wd = e.wd; h_r15 = e.r15;
      end
    end else begin
      check("idle_strobes", {RegWrite, r15_we, ovf, illegal}, 0);
      check("hold_Writedata", Writedata, h_wd);
      check("hold_r15_data", r15_data, h_r15);
    end
    if (in_valid && in_ready && !reset) begin
      e = model(opcode, funct, op1, op2, r15_sel);
      exq.push_back(e);
      m_wd = e.wd; m_r15 = e.r15;
      ready_from = (e.due - cyc == 17) ? cyc + 18 : cyc + 1;
      last_acc = cyc;
      acc_flag = 1;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      in_valid = 1'b0;
      opcode = 4'($urandom); funct = 4'($urandom);
      op1 = 16'($urandom); op2 = 16'($urandom); r15_sel = 1'($urandom);
      cycle();
    end
  endtask

  // Upstream holds the instruction steady until it is taken.
  task automatic issue(input logic [3:0] opc, input logic [3:0] fn,
                       input logic [15:0] a, input logic [15:0] b, input logic rs);
    bit taken;
    taken = 0;
    in_valid = 1'b1; opcode = opc; funct = fn; op1 = a; op2 = b; r15_sel = rs;
    for (int i = 0; i < 60 && !taken; i++) begin
      cycle();
      taken = acc_flag;
    end
    in_valid = 1'b0;
    if (!taken) check("accept_timeout", 0, 1);
  endtask

  function automatic logic [15:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic check_cleared(input string tag);
    @(negedge clk);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_strobes"}, {out_valid, RegWrite, r15_we, ovf, illegal}, 0);
    check({tag, "_Writedata"}, Writedata, 0);
    check({tag, "_r15_data"}, r15_data, 0);
    @(posedge clk);
    cyc++;
    #1;
  endtask

  initial begin
    int t0;
    reset = 1'b1; in_valid = 1'b0; opcode = '0; funct = '0; op1 = '0; op2 = '0; r15_sel = 1'b0;
    repeat (3) begin @(posedge clk); cyc++; end
    #1 reset = 1'b0;
    check_cleared("reset");

    issue(OPC_TYPEA, F_ADD, 16'h0F00, 16'h0050, 1'b0);
    t0 = last_acc;
    issue(OPC_TYPEA, F_ADD, 16'h7FFF, 16'h0001, 1'b0);
    check("add_back_to_back", last_acc - t0, 1);
    issue(OPC_TYPEA, F_SUB, 16'h0050, 16'h0F00, 1'b1);
    issue(OPC_TYPEA, F_MUL, 16'h0040, 16'h6666, 1'b1);
    t0 = last_acc;
    issue(OPC_TYPEA, F_DIV, 16'h6666, 16'h0040, 1'b1);
    check("held_during_mul", last_acc - t0, 18);
    t0 = last_acc;
    issue(OPC_TYPEA, F_DIV, 16'hCCCC, 16'h0000, 1'b0);
    check("held_during_div", last_acc - t0, 18);
    idle(20);

    // Abort a MUL partway through; its result must never appear.
    issue(OPC_TYPEA, F_MUL, 16'h1234, 16'h5678, 1'b1);
    t0 = last_acc;
    while (cyc < t0 + 8) idle(1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    exq.delete();
    m_wd = '0; m_r15 = '0; h_wd = '0; h_r15 = '0; ready_from = 0;
    check_cleared("abort");
    idle(25);
    issue(4'h2, F_ADD, 16'h1111, 16'h2222, 1'b0);
    idle(2);

    for (int n = 0; n < 250; n++) begin
      logic [3:0] opc;
      opc = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 14)) : OPC_TYPEA;
      issue(opc, 4'($urandom_range(0, 7)), rand_operand(), rand_operand(), 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(20);
    check("drain_pending", exq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
